// File: rtl/motor_pkg.sv
// motor_pkg: mode encoding, channel state enum and default widths shared by motor_pwm_drive.
package motor_pkg;
    localparam int PWM_BITS_DEF = 8;
    localparam logic [1:0] MODE_COAST = 2'b00;
    localparam logic [1:0] MODE_FWD   = 2'b01;
    localparam logic [1:0] MODE_REV   = 2'b10;
    localparam logic [1:0] MODE_BRAKE = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DEAD, BRAKE} ch_state_t;
endpackage

// File: rtl/motor_pwm_channel.sv
// motor_pwm_channel: one H-bridge side - mode FSM, dead time, duty ramp, PWM shadow and pin decode.
// The soft duty ramp exists only when MOTOR_RAMP_EN is defined.
module motor_pwm_channel
    import motor_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int DEADTIME = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_stb,
    input  logic [1:0]          i_mode,
    input  logic [PWM_BITS-1:0] i_duty,
`ifdef MOTOR_RAMP_EN
    input  logic                i_ramp_tick,
`endif
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_wrap,
    output logic [1:0]          o_in,
    output logic                o_en,
    output logic                o_dead,
    output logic                o_busy
);
    localparam int DT_W = DEADTIME > 1 ? $clog2(DEADTIME) : 1;

    ch_state_t           r_state, w_nxt;
    logic                r_dir, r_pend;
    logic [DT_W-1:0]     r_dead_cnt;
    logic [PWM_BITS-1:0] r_cur, r_tgt, r_shadow;
    logic                w_drive, w_rev, w_pend_now, w_expire;

    assign w_drive    = i_cmd_stb && (i_mode == MODE_FWD || i_mode == MODE_REV);
    assign w_rev      = i_mode == MODE_REV;
    assign w_pend_now = w_drive ? w_rev : r_pend;
    assign w_expire   = r_state == DEAD && r_dead_cnt == '0;

    always_ff @(posedge clk)
        if (rst) r_state <= IDLE;
        else r_state <= w_nxt;

    // Coast/brake override everything; drive commands during DEAD only retarget the pending run.
    always_comb
        w_nxt = (i_cmd_stb && i_mode == MODE_COAST) ? IDLE :
                (i_cmd_stb && i_mode == MODE_BRAKE) ? BRAKE :
                r_state == DEAD ? (w_expire ? RUN : DEAD) :
                !w_drive ? r_state :
                (r_state == RUN && w_rev != r_dir) ? DEAD : RUN;

    always_comb begin
        o_in   = r_state == RUN ? (r_dir ? 2'b10 : 2'b01) : r_state == BRAKE ? 2'b11 : 2'b00;
        o_en   = r_state == BRAKE || (r_state == RUN && i_pwm_cnt < r_shadow);
        o_dead = r_state == DEAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir      <= 1'b0;
            r_pend     <= 1'b0;
            r_dead_cnt <= '0;
            r_tgt      <= '0;
            r_shadow   <= '0;
        end else begin
            if (w_drive) begin
                r_pend <= w_rev;
                r_tgt  <= i_duty;
            end
            if (w_nxt == RUN && r_state != RUN) r_dir <= w_pend_now;
            if (w_nxt == DEAD && r_state != DEAD) r_dead_cnt <= DT_W'(DEADTIME - 1);
            else if (r_dead_cnt != '0) r_dead_cnt <= r_dead_cnt - 1'b1;
            // Cleared outside RUN so a fresh run never replays a stale duty before the next wrap.
            if (w_nxt != RUN) r_shadow <= '0;
            else if (i_wrap) r_shadow <= r_cur;
        end
    end

`ifdef MOTOR_RAMP_EN
    always_ff @(posedge clk)
        if (rst) r_cur <= '0;
        else if (i_cmd_stb) r_cur <= (r_state == RUN && w_nxt == RUN) ? r_cur : '0;
        else if (i_ramp_tick && r_state == RUN && r_cur != r_tgt)
            r_cur <= r_cur < r_tgt ? r_cur + 1'b1 : r_cur - 1'b1;

    assign o_busy = o_dead || (r_state == RUN && r_cur != r_tgt);
`else
    always_ff @(posedge clk)
        if (rst) r_cur <= '0;
        else r_cur <= w_nxt == RUN ? (w_drive ? i_duty : r_tgt) : '0;

    assign o_busy = o_dead;
`endif
endmodule

// File: rtl/motor_pwm_drive.sv
// motor_pwm_drive: two-side L298-style H-bridge stage with command handshake, shared PWM timebase and dead time.
// Define MOTOR_RAMP_EN for the soft duty ramp; otherwise duty steps straight to target at the next period.
module motor_pwm_drive
    import motor_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = 16,
    parameter int RAMP_DIV = 39062,
    parameter int DEADTIME = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_left,
    input  logic [1:0]          cmd_right,
    input  logic [PWM_BITS-1:0] cmd_duty,
    output logic [3:0]          motor_in,
    output logic [1:0]          motor_en,
    output logic                busy
);
    localparam int PRE_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_pwm_cnt, r_duty;
    logic [1:0]          r_left, r_right;
    logic                r_stb;
    logic                w_accept, w_pwm_tick, w_wrap;
    logic [1:0]          w_dead, w_busy;

    assign cmd_ready  = !rst && w_dead == 2'b00;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_pwm_tick = r_pre == PRE_W'(PRESCALE - 1);
    assign w_wrap     = w_pwm_tick && r_pwm_cnt == '1;
    assign busy       = |w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre     <= '0;
            r_pwm_cnt <= '0;
            r_stb     <= 1'b0;
            r_left    <= MODE_COAST;
            r_right   <= MODE_COAST;
            r_duty    <= '0;
        end else begin
            r_pre <= w_pwm_tick ? '0 : r_pre + 1'b1;
            if (w_pwm_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_stb <= w_accept;
            if (w_accept) begin
                r_left  <= cmd_left;
                r_right <= cmd_right;
                r_duty  <= cmd_duty;
            end
        end
    end

`ifdef MOTOR_RAMP_EN
    localparam int RAMP_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;

    logic [RAMP_W-1:0] r_ramp_pre;
    logic              w_ramp_tick;

    // Free-running: commands never restart the ramp cadence.
    assign w_ramp_tick = r_ramp_pre == RAMP_W'(RAMP_DIV - 1);

    always_ff @(posedge clk)
        if (rst) r_ramp_pre <= '0;
        else r_ramp_pre <= w_ramp_tick ? '0 : r_ramp_pre + 1'b1;
`endif

    motor_pwm_channel #(.PWM_BITS(PWM_BITS), .DEADTIME(DEADTIME)) u_left (
        .clk        (clk),
        .rst        (rst),
        .i_cmd_stb  (r_stb),
        .i_mode     (r_left),
        .i_duty     (r_duty),
`ifdef MOTOR_RAMP_EN
        .i_ramp_tick(w_ramp_tick),
`endif
        .i_pwm_cnt  (r_pwm_cnt),
        .i_wrap     (w_wrap),
        .o_in       (motor_in[1:0]),
        .o_en       (motor_en[1]),
        .o_dead     (w_dead[0]),
        .o_busy     (w_busy[0])
    );

    motor_pwm_channel #(.PWM_BITS(PWM_BITS), .DEADTIME(DEADTIME)) u_right (
        .clk        (clk),
        .rst        (rst),
        .i_cmd_stb  (r_stb),
        .i_mode     (r_right),
        .i_duty     (r_duty),
`ifdef MOTOR_RAMP_EN
        .i_ramp_tick(w_ramp_tick),
`endif
        .i_pwm_cnt  (r_pwm_cnt),
        .i_wrap     (w_wrap),
        .o_in       (motor_in[3:2]),
        .o_en       (motor_en[0]),
        .o_dead     (w_dead[1]),
        .o_busy     (w_busy[1])
    );
endmodule

// File: doc/motor_pwm_drive.md
# motor_pwm_drive

Two-channel H-bridge drive stage between the rover's steering/decision logic and the L298-style driver pins (IN1–IN4, ENA/ENB). It accepts a per-side direction command and a shared target duty through a valid/ready handshake. It produces glitch-free PWM on the enables, with a soft ramp on duty and an enforced dead time on direction reversal. Its outputs drive the motor header pins directly.

## Interface
- PWM_BITS, 8: duty and PWM counter width.
- PRESCALE, 16: clk cycles per PWM counter step. At 100 MHz this gives ≈24.4 kHz PWM.
- RAMP_DIV, 39062: clk cycles per one-LSB duty ramp step. A full 0→255 ramp takes ≈0.1 s.
- DEADTIME, 100000: clk cycles with a bridge fully off on reversal (1 ms).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_left  in  2  left side mode: 00 coast, 01 forward, 10 reverse, 11 brake.
- cmd_right  in  2  right side mode, same encoding.
- cmd_duty  in  PWM_BITS  target duty, shared by both sides.
- motor_in  out  4  {IN4,IN3,IN2,IN1}. [1:0] is left, [3:2] is right.
- motor_en  out  2  {ENA,ENB}. ENA is left, ENB is right.
- busy  out  1  either channel is in DEAD or still ramping.

## Operation
- A command is accepted on a cycle with cmd_valid && cmd_ready. The fields are registered, and the channels act on them the following cycle.
- cmd_ready is 0 while either channel is in DEAD, and 1 otherwise (outside reset).
- Pin encoding per side:
  - forward: INa=1, INb=0
  - reverse: INa=0, INb=1
  - coast/DEAD: both 0, EN=0
  - brake: both 1, EN=1 constant
- Channel FSM states: IDLE, RUN, DEAD, BRAKE. Transitions on an accepted command:
  - coast → IDLE from any state. duty_cur=0.
  - brake → BRAKE from any state. duty_cur=0.
  - fwd/rev from IDLE or BRAKE → RUN in that direction. duty_cur starts at 0.
  - fwd/rev in RUN, same direction → stay in RUN. Only the target changes.
  - fwd/rev in RUN, opposite direction → DEAD. duty_cur=0. The pending direction is stored.
  - DEAD → RUN in the pending direction after exactly DEADTIME cycles.
  - New commands cannot arrive during DEAD, because ready is low.
- Ramp: every RAMP_DIV clk cycles, duty_cur moves one LSB toward duty_tgt. It saturates at the target and never overshoots.
- A lower target ramps down in the same way.
- PWM:
  - One shared counter pwm_cnt, incremented once per PRESCALE cycles, wrapping from 2^PWM_BITS−1 to 0.
  - Each side has a shadow duty register, loaded from duty_cur only when pwm_cnt wraps to 0.
  - EN = (pwm_cnt < shadow) in RUN. Duty 0 keeps EN low; duty 255 gives 255/256 high.
- busy = any DEAD || any RUN channel with duty_cur ≠ duty_tgt.

## Timing
- Reset values:
  - motor_in=0000, motor_en=00, busy=0, cmd_ready=0 while rst is high.
  - cmd_ready=1 on the first cycle after rst falls.
  - Counters, duty_cur, shadows = 0. FSM = IDLE.
- rst takes priority over every event. Asserting it mid-DEAD or mid-ramp returns all outputs to 0 on the next edge.
- motor_in changes 1 cycle after command accept. There is no direct combinational path from cmd_* to the outputs.
- A new duty becomes visible on EN only at the next PWM period boundary. There are no partial-period glitches.
- A ramp tick coinciding with a new command: the command wins, and the ramp prescaler is not reset.
- Entering DEAD forces EN=0 and IN=00 on the same edge. No cycle ever drives both direction pins toward a reversal without the gap.

## Configuration
- MOTOR_RAMP_EN defined: soft ramp as described above.
- MOTOR_RAMP_EN not defined:
  - duty_cur equals duty_tgt immediately on accept. It still reaches EN only at the period boundary.
  - The ramp prescaler is removed.
  - busy reflects DEAD only.

## Structure
- Shared package motor_pkg holds:
  - mode encoding constants (MODE_COAST, MODE_FWD, MODE_REV, MODE_BRAKE)
  - channel state enum (IDLE, RUN, DEAD, BRAKE)
  - default PWM_BITS
- One sub-module, motor_pwm_channel. It contains the FSM, ramp, dead-time counter, shadow register and pin decode, and is instantiated twice.
- The top level owns:
  - the command register and handshake
  - the PWM counter and prescaler
  - the ramp prescaler, with its tick shared by both channels

## Test plan
Bench parameters: PRESCALE=1, RAMP_DIV=4, DEADTIME=8, PWM_BITS=8.
- Reset: hold rst 5 cycles → motor_in=0000, motor_en=00, cmd_ready=0. One cycle after release → cmd_ready=1.
- Forward both sides, duty 64 (ramp on) → motor_in=0101 one cycle later. duty_cur reaches 64 after 256 clk. Steady EN is high for 64 of every 256 cycles.
- Left fwd→rev while at duty 64 → left IN=00 and ENA=0 for exactly 8 cycles, with cmd_ready=0. Then left IN=10, ramping from 0. The right side is unaffected.
- Brake left, coast right → motor_in=0011, motor_en=10 constant. busy=0.
- Target change 64→200 mid-period → EN pulse width changes only at pwm_cnt wrap. Without MOTOR_RAMP_EN, the very next period is 200/256.
- rst asserted during DEAD → all outputs 0 next edge. After release, the FSM is IDLE and accepts a new fwd command normally.
